// File: rtl/dmem_responder_pkg.sv
// Shared RV32I data-memory definitions: widths, load/store funct3 codes, responder states, request payload.
package riscv_defs;

  localparam int unsigned NB_WORD = 32;
  localparam int unsigned NB_ADDR = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_st_funct3_t;

  // Stores share the size encoding of the signed loads
  localparam ld_st_funct3_t SB = LB;
  localparam ld_st_funct3_t SH = LH;
  localparam ld_st_funct3_t SW = LW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_rsp_state_t;

  typedef struct packed {
    logic               we;
    logic [NB_ADDR-1:0] addr;
    logic [NB_WORD-1:0] wdata;
    logic [2:0]         funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the MEM-stage initiator (master) and the responder (slave).
interface dmem_responder_if #(
  parameter int unsigned NB_WORD = riscv_defs::NB_WORD,
  parameter int unsigned NB_ADDR = riscv_defs::NB_ADDR
);
  logic               req;
  logic               we;
  logic [NB_ADDR-1:0] addr;
  logic [NB_WORD-1:0] wdata;
  logic [2:0]         funct3;
  logic               ready;
  logic               rvalid;
  logic [NB_WORD-1:0] rdata;
  logic               err;

  modport master (output req, we, addr, wdata, funct3,
                  input  ready, rvalid, rdata, err);
  modport slave  (input  req, we, addr, wdata, funct3,
                  output ready, rvalid, rdata, err);
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane steering: byte enables, shifted store data, extracted/extended load data,
// illegal-funct3 and misalignment flags. Misaligned offsets are forced down to the access size.
module dmem_lane_align
  import riscv_defs::*;
(
  input  logic [2:0]         funct3,
  input  logic               we,
  input  logic [1:0]         offset,
  input  logic [NB_WORD-1:0] wdata,
  input  logic [NB_WORD-1:0] rword,
  output logic [3:0]         be_c,
  output logic [NB_WORD-1:0] wdata_c,
  output logic [NB_WORD-1:0] rdata_c,
  output logic               illegal_c,
  output logic               misaligned_c
);

  logic [1:0]         eff_off;
  logic [4:0]         shamt;
  logic [3:0]         base_be;
  logic               sext;
  logic [NB_WORD-1:0] rshift;

  always_comb begin
    illegal_c    = 1'b0;
    misaligned_c = 1'b0;
    eff_off      = offset;
    base_be      = 4'b0001;
    sext         = 1'b0;
    case (funct3)
      LB:  sext = 1'b1;
      LH:  begin
             base_be      = 4'b0011;
             sext         = 1'b1;
             misaligned_c = offset[0];
             eff_off      = {offset[1], 1'b0};
           end
      LW:  begin
             base_be      = 4'b1111;
             misaligned_c = |offset;
             eff_off      = 2'b00;
           end
      LBU: illegal_c = we;
      LHU: begin
             base_be      = 4'b0011;
             misaligned_c = offset[0];
             eff_off      = {offset[1], 1'b0};
             illegal_c    = we;
           end
      default: illegal_c = 1'b1;
    endcase

    shamt   = {eff_off, 3'b000};
    rshift  = rword >> shamt;
    wdata_c = wdata << shamt;
    be_c    = illegal_c ? 4'b0000 : (base_be << eff_off);

    rdata_c = '0;
    if (!illegal_c) begin
      case (base_be)
        4'b0001: rdata_c = {{24{sext & rshift[7]}}, rshift[7:0]};
        4'b0011: rdata_c = {{16{sext & rshift[15]}}, rshift[15:0]};
        default: rdata_c = rshift;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access per handshake, WAIT_CYCLES wait states, RV32I lane handling.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned half/word accesses as errors instead of aligning them down.
module dmem_responder #(
  parameter int unsigned NB_WORD     = riscv_defs::NB_WORD,
  parameter int unsigned NB_ADDR     = riscv_defs::NB_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  dmem_responder_if.slave  bus
);
  import riscv_defs::*;

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  logic [NB_WORD-1:0] mem [DEPTH_WORDS];

  dmem_rsp_state_t    state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               accept_c;
  logic               enter_resp_c;

  dmem_req_t          req_q;
  dmem_req_t          req_in;
  dmem_req_t          req_cur;
  logic [AW-1:0]      widx;

  logic [3:0]         be_c;
  logic [NB_WORD-1:0] wdata_al_c;
  logic [NB_WORD-1:0] rdata_al_c;
  logic               illegal_c;
  logic               misaligned_c;
  logic               err_c;
  logic               mem_we_c;

  logic               ready_q;
  logic               rvalid_q;
  logic [NB_WORD-1:0] rdata_q;
  logic               err_q;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state; the access itself happens on the edge that enters RESP
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    accept_c     = 1'b0;
    enter_resp_c = 1'b0;
    case (state)
      IDLE: if (bus.req) begin
              accept_c = 1'b1;
              if (WAIT_CYCLES == 0) begin
                state_d      = RESP;
                enter_resp_c = 1'b1;
              end else begin
                state_d = WAIT;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
              end
            end
      WAIT: if (cnt == '0) begin
              state_d      = RESP;
              enter_resp_c = 1'b1;
            end else begin
              cnt_d = cnt - CNT_W'(1);
            end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access uses the request on the bus in the accept cycle
  always_comb begin
    req_in.we     = bus.we;
    req_in.addr   = bus.addr;
    req_in.wdata  = bus.wdata;
    req_in.funct3 = bus.funct3;
    req_cur       = (state == IDLE) ? req_in : req_q;
  end

  always_ff @(posedge i_clock) begin
    if (accept_c) req_q <= req_in;
  end

  assign widx = req_cur.addr[AW+1:2];

  dmem_lane_align u_lane_align (
    .funct3       (req_cur.funct3),
    .we           (req_cur.we),
    .offset       (req_cur.addr[1:0]),
    .wdata        (req_cur.wdata),
    .rword        (mem[widx]),
    .be_c         (be_c),
    .wdata_c      (wdata_al_c),
    .rdata_c      (rdata_al_c),
    .illegal_c    (illegal_c),
    .misaligned_c (misaligned_c)
  );

`ifdef DMEM_MISALIGN_CHK_EN
  assign err_c = illegal_c | misaligned_c;
`else
  assign err_c = illegal_c;
`endif

  assign mem_we_c = enter_resp_c & req_cur.we & ~err_c & ~i_reset;

  // Storage array is never reset
  always_ff @(posedge i_clock) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[widx][8*b +: 8] <= wdata_al_c[8*b +: 8];
      end
    end
  end

  // Response registers; rdata/err are held at zero outside the completion pulse
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q  <= (state_d == IDLE);
      rvalid_q <= enter_resp_c;
      err_q    <= enter_resp_c & err_c;
      rdata_q  <= (enter_resp_c && !req_cur.we && !err_c) ? rdata_al_c : '0;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, req_cur.addr[NB_ADDR-1:AW+2], misaligned_c};

endmodule
